// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the instruction memory and buffers {pc, instr} pairs in a FIFO.
// Optional FETCH_QUEUE_BYPASS_EN presents the current fetch on deq_* when the queue is empty in RUN.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic [XLEN-1:0]            imem_addr_o,
  output logic                       imem_req_o,
  input  logic [XLEN-1:0]            imem_instr_i,
  output logic                       deq_valid_o,
  output logic [XLEN-1:0]            deq_pc_o,
  output logic [XLEN-1:0]            deq_instr_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  // Handshakes (valid/ready): a transfer happens on an edge where valid and ready
  // are both high; valid never depends on ready, and ready may be asserted freely.
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [XLEN-1:0] r_mem_instr [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_head_pc;
  logic [XLEN-1:0] r_head_instr;

  logic            w_run;
  logic            w_bypass;
  logic            w_deq_valid;
  logic            w_deq;
  logic            w_enq;
  logic            w_wr;
  logic            w_pop;
  logic            w_flush;
  logic [CW-1:0]   w_count_next;
  logic [CW-1:0]   w_count_after_pop;
  logic [PW-1:0]   w_rptr_next;
  logic [XLEN-1:0] w_head_pc_next;
  logic [XLEN-1:0] w_head_instr_next;

  assign w_run = (r_state == ST_RUN);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_run & (r_count == '0) & ~redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_deq_valid = (r_count != '0) | w_bypass;
  assign w_deq       = w_deq_valid & deq_ready_i;
  assign w_enq       = w_run & ~redirect_i & ((r_count != FULL) | w_deq);
  // A bypassed fetch is consumed straight from the memory and never written.
  assign w_wr        = w_enq & ~(w_bypass & deq_ready_i);
  assign w_pop       = w_deq & ~w_bypass;
  assign w_flush     = w_run & redirect_i;

  assign w_count_after_pop = r_count - CW'(w_pop);

  always_comb begin
    w_count_next      = w_count_after_pop + CW'(w_wr);
    w_rptr_next       = r_rptr + PW'(w_pop);
    w_head_pc_next    = r_head_pc;
    w_head_instr_next = r_head_instr;
    if (w_flush) begin
      w_count_next = '0;
      w_rptr_next  = '0;
    end else if (w_count_next != '0) begin
      // Queue drains to empty before this write: the new head is the incoming word.
      if (w_count_after_pop == '0) begin
        w_head_pc_next    = r_pc;
        w_head_instr_next = imem_instr_i;
      end else begin
        w_head_pc_next    = r_mem_pc[w_rptr_next];
        w_head_instr_next = r_mem_instr[w_rptr_next];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_head_pc    <= '0;
      r_head_instr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
      r_count      <= w_count_next;
      r_rptr       <= w_rptr_next;
      r_head_pc    <= w_head_pc_next;
      r_head_instr <= w_head_instr_next;
      if (w_flush) begin
        r_wptr <= '0;
        r_pc   <= redirect_pc_i & ~XLEN'(1);
      end else begin
        if (w_wr)  r_wptr <= r_wptr + PW'(1);
        if (w_enq) r_pc   <= r_pc + STEP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem_pc[r_wptr]    <= r_pc;
      r_mem_instr[r_wptr] <= imem_instr_i;
    end
  end

  assign imem_addr_o = r_pc;
  assign imem_req_o  = w_enq;
  assign deq_valid_o = w_deq_valid;
  assign count_o     = r_count;
  assign dbg_state_o = r_state;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign deq_pc_o    = w_bypass ? r_pc : r_head_pc;
  assign deq_instr_o = w_bypass ? imem_instr_i : r_head_instr;
`else
  assign deq_pc_o    = r_head_pc;
  assign deq_instr_o = r_head_instr;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random stimulus, checked every cycle against a queue-based model.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          PC_STEP  = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_instr_i;
  logic        deq_valid_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_instr_o;
  logic        deq_ready_i = 1'b0;
  logic [2:0]  count_o;
  logic        dbg_state_o;
  logic        nop_mode = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected queue contents {pc, instr}, fetch PC, run flag, last shown head.
  logic [2*XLEN-1:0] exp_q[$];
  logic [31:0]       m_pc = RESET_PC;
  bit                m_run = 1'b0;
  logic [2*XLEN-1:0] m_last = '0;
  bit                m_have_last = 1'b0;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_req_o(imem_req_o),
    .imem_instr_i(imem_instr_i), .deq_valid_o(deq_valid_o), .deq_pc_o(deq_pc_o),
    .deq_instr_o(deq_instr_o), .deq_ready_i(deq_ready_i), .count_o(count_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem_word(input logic [31:0] a, input logic nop);
    return nop ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_5A5A);
  endfunction

  assign imem_instr_i = imem_word(imem_addr_o, nop_mode);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, compare settled outputs, then advance the model.
  task automatic cycle(input logic rst, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic rdy, input logic nop);
    bit          byp, ev, er, deq;
    logic [31:0] hp, hi;
    @(negedge clk_i);
    rst_i = rst; start_i = st; redirect_i = rd; redirect_pc_i = rpc;
    deq_ready_i = rdy; nop_mode = nop;
    #1;
    byp = BYP && m_run && exp_q.size() == 0 && !rd;
    ev  = exp_q.size() != 0 || byp;
    deq = ev && rdy;
    er  = m_run && !rd && (exp_q.size() < DEPTH || deq);
    check("imem_req", 64'(imem_req_o), 64'(er));
    check("imem_addr", 64'(imem_addr_o), 64'(m_pc));
    check("deq_valid", 64'(deq_valid_o), 64'(ev));
    check("count", 64'(count_o), 64'(exp_q.size()));
    if (ev) begin
      hp = byp ? m_pc : exp_q[0][63:32];
      hi = byp ? imem_word(m_pc, nop) : exp_q[0][31:0];
      check("deq_pc", 64'(deq_pc_o), 64'(hp));
      check("deq_instr", 64'(deq_instr_o), 64'(hi));
    end else if (!BYP && m_have_last) begin
      check("hold_pc", 64'(deq_pc_o), 64'(m_last[63:32]));
      check("hold_instr", 64'(deq_instr_o), 64'(m_last[31:0]));
    end
    if (rst) begin
      m_run = 1'b0; m_pc = RESET_PC; exp_q.delete(); m_have_last = 1'b0;
    end else if (!m_run) begin
      if (st) m_run = 1'b1;
    end else if (rd) begin
      exp_q.delete();
      m_pc = rpc & ~32'h1;
    end else begin
      if (deq && !byp) void'(exp_q.pop_front());
      if (er) begin
        if (!(byp && rdy)) exp_q.push_back({m_pc, imem_word(m_pc, nop)});
        m_pc = m_pc + PC_STEP;
      end
    end
    if (exp_q.size() != 0) begin
      m_last = exp_q[0]; m_have_last = 1'b1;
    end
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    cycle(0, 0, 0, 0, 1, 1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(deq_valid_o), 64'd0);
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_addr", 64'(imem_addr_o), 64'(RESET_PC));

    // Streaming nops with decode always ready
    cycle(0, 1, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
      check("nop_pc", 64'(deq_pc_o), 64'(i * 4));
      check("nop_count", 64'(count_o), 64'd1);
`endif
    end

    // Fill to saturation with decode stalled
    do_reset();
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_req", 64'(imem_req_o), 64'd0);
    check("full_addr", 64'(imem_addr_o), 64'h10);
    check("full_head", 64'(deq_pc_o), 64'h0);
    cycle(0, 0, 0, 0, 1, 0);
    check("full_deq_req", 64'(imem_req_o), 64'd1);
    cycle(0, 0, 0, 0, 0, 0);
    check("full_deq_count", 64'(count_o), 64'd4);
    check("full_deq_head", 64'(deq_pc_o), 64'h4);

    // Redirect with three entries queued
    do_reset();
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h101, 0, 0);
    check("redir_pre_count", 64'(count_o), 64'd3);
    cycle(0, 0, 0, 0, 0, 0);
    check("redir_count", 64'(count_o), 64'd0);
    check("redir_addr", 64'(imem_addr_o), 64'h100);
`ifndef FETCH_QUEUE_BYPASS_EN
    check("redir_valid", 64'(deq_valid_o), 64'd0);
`endif
    cycle(0, 0, 0, 0, 0, 0);
    check("redir_head", 64'(deq_pc_o), 64'h100);

    // Redirect together with a dequeue
    cycle(0, 0, 1, 32'h200, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("redir_deq_count", 64'(count_o), 64'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);

    // Reset in the middle of a run, then stay idle
    do_reset();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("mid_rst_pre_count", 64'(count_o), 64'd2);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, $urandom_range(0, 1), 0);
      check("idle_count", 64'(count_o), 64'd0);
      check("idle_req", 64'(imem_req_o), 64'd0);
      check("idle_addr", 64'(imem_addr_o), 64'(RESET_PC));
    end

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_st, r_rd, r_rdy, r_nop;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 3));
      r_nop = ($urandom_range(0, 7) == 0);
      cycle(r_rst, r_st, r_rd, $urandom, r_rdy, r_nop);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
